// File: rtl/tick_gen.sv
// tick_gen: cascaded programmable tick divider with shadowed, glitch-free divisor reload.
// Define TICK_GEN_FRAC_EN to build the stage-0 fractional period accumulator.
module tick_gen #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 24,
  parameter int FRAC_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_en,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic [STAGES*CNT_W-1:0] i_div,
  input  logic [FRAC_W-1:0]       i_frac,
  output logic [STAGES-1:0]       o_tick,
  output logic                    o_load_done
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(2);

  logic [CNT_W-1:0]  cnt_q     [STAGES];
  logic [CNT_W-1:0]  act_div_q [STAGES];
  logic [CNT_W-1:0]  shd_div_q [STAGES];
  logic [CNT_W-1:0]  term      [STAGES];
  logic [STAGES-1:0] tick_q;
  logic [STAGES-1:0] pend_q;
  logic [STAGES-1:0] pend_d;
  logic [STAGES-1:0] ev_src;
  logic [STAGES-1:0] ev;
  logic [STAGES-1:0] wrap;
  logic [STAGES-1:0] adopt;
  logic              load_done_q;
  logic              extend;

  // Stage 0 counts every enabled cycle; each later stage counts the previous stage's tick.
  assign ev_src = STAGES'({tick_q, 1'b1});

  always_comb begin
    ev    = '0;
    wrap  = '0;
    adopt = '0;
    for (int k = 0; k < STAGES; k++) begin
      term[k] = (act_div_q[k] < DIV_RST) ? '0 : act_div_q[k] - CNT_W'(1);
      ev[k]   = i_en & ev_src[k];
    end
    term[0] = term[0] + CNT_W'(extend);
    for (int k = 0; k < STAGES; k++) begin
      wrap[k]  = ev[k] & (cnt_q[k] == term[k]);
      // An idle stage sitting at zero may switch divisor without disturbing its period.
      adopt[k] = i_en & pend_q[k] & (wrap[k] | ((cnt_q[k] == '0) & ~ev[k]));
    end
  end

  assign pend_d = i_load ? '1 : (pend_q & ~adopt);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tick_q      <= '0;
      pend_q      <= '0;
      load_done_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        cnt_q[k]     <= '0;
        act_div_q[k] <= DIV_RST;
        shd_div_q[k] <= DIV_RST;
      end
    end else if (i_clear) begin
      tick_q      <= '0;
      pend_q      <= '0;
      load_done_q <= (|pend_q) | i_load;
      for (int k = 0; k < STAGES; k++) begin
        cnt_q[k] <= '0;
        if (i_load) begin
          act_div_q[k] <= i_div[k*CNT_W +: CNT_W];
          shd_div_q[k] <= i_div[k*CNT_W +: CNT_W];
        end else begin
          act_div_q[k] <= shd_div_q[k];
        end
      end
    end else begin
      if (i_en) tick_q <= wrap;
      pend_q      <= pend_d;
      // A reload landing while flags are still pending suppresses the pulse.
      load_done_q <= (|pend_q) & ~(|pend_d);
      for (int k = 0; k < STAGES; k++) begin
        if (ev[k]) cnt_q[k] <= wrap[k] ? '0 : cnt_q[k] + CNT_W'(1);
        if (adopt[k]) act_div_q[k] <= shd_div_q[k];
        if (i_load) shd_div_q[k] <= i_div[k*CNT_W +: CNT_W];
      end
    end
  end

`ifdef TICK_GEN_FRAC_EN
  logic [FRAC_W-1:0] act_frac_q;
  logic [FRAC_W-1:0] shd_frac_q;
  logic [FRAC_W-1:0] acc_q;
  logic              ext_q;

  // A carry out of the accumulator stretches the following stage-0 period by one cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      act_frac_q <= '0;
      shd_frac_q <= '0;
      acc_q      <= '0;
      ext_q      <= 1'b0;
    end else if (i_clear) begin
      acc_q <= '0;
      ext_q <= 1'b0;
      if (i_load) begin
        act_frac_q <= i_frac;
        shd_frac_q <= i_frac;
      end else begin
        act_frac_q <= shd_frac_q;
      end
    end else begin
      if (wrap[0]) {ext_q, acc_q} <= {1'b0, acc_q} + {1'b0, act_frac_q};
      if (adopt[0]) act_frac_q <= shd_frac_q;
      if (i_load) shd_frac_q <= i_frac;
    end
  end

  assign extend = ext_q;
`else
  logic unused_frac;
  assign unused_frac = ^i_frac;
  assign extend      = 1'b0;
`endif

  assign o_tick      = tick_q & {STAGES{i_en}};
  assign o_load_done = load_done_q;

endmodule
